ascii_pattern_gen: RTL

Parametrised ASCII test-pattern source that feeds `uart_tx2` through its `TX_DV`/`DONE` handshake. It generates line-structured text in one of three run-time modes: sawtooth, full ramp, or binary counter. It runs fully synchronously in the `CLK` domain. It is the bring-up and link-soak traffic source for the serial designs on the board.

---
 rtl/ascii_pattern_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ascii_pattern_gen.sv
// Line-structured ASCII pattern source (sawtooth / ramp / binary counter) for a UART transmitter.
// Latency: TX_DV 1 cycle after ENABLE sampled in IDLE, and 1 cycle after each TX_DONE.
// Backpressure: one byte in flight, next byte waits for TX_DONE. Optional ASCII_PATGEN_CR_EN adds CR before EOL.
module ascii_pattern_gen #(
    parameter logic [7:0] FIRST_CHAR = 8'h30,
    parameter logic [7:0] LAST_CHAR  = 8'h7A,
    parameter logic [7:0] EOL_CHAR   = 8'h0A,
    parameter int         COUNT_W    = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ENABLE,
    input  logic [1:0] MODE,
    input  logic       TX_DONE,
    output logic       TX_DV,
    output logic [7:0] TX_BYTE,
    output logic       LINE_DONE,
    output logic       BUSY
);

    localparam int                IDX_W   = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
    localparam logic [7:0]        SPAN    = LAST_CHAR - FIRST_CHAR;
    localparam logic [IDX_W-1:0]  TOP_BIT = IDX_W'(COUNT_W - 1);
    localparam logic [7:0]        ASCII_0 = 8'h30;
    localparam logic [7:0]        ASCII_1 = 8'h31;
`ifdef ASCII_PATGEN_CR_EN
    localparam logic [7:0]        CR_CHAR = 8'h0D;
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    typedef enum logic [1:0] {PH_DATA, PH_CR, PH_EOL} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         k_q, k_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]         pos_q, pos_d;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [7:0]         byte_q, byte_d;
    logic               line_start;
    logic               data_last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            phase_q <= PH_DATA;
            mode_q  <= 2'd0;
            k_q     <= 8'd0;
            cnt_q   <= '0;
            pos_q   <= 8'd0;
            bit_q   <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

    // Mode 3 is treated as ramp, so only sawtooth and counter get special cases.
    always_comb begin
        case (mode_q)
            2'd0:    data_last = (pos_q == k_q);
            2'd2:    data_last = (bit_q == '0);
            default: data_last = (pos_q == SPAN);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        mode_d     = mode_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        line_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (ENABLE) line_start = 1'b1;
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (TX_DONE) begin
                    state_d = SEND;
                    case (phase_q)
                        PH_DATA: begin
                            if (data_last) begin
`ifdef ASCII_PATGEN_CR_EN
                                phase_d = PH_CR;
                                byte_d  = CR_CHAR;
`else
                                phase_d = PH_EOL;
                                byte_d  = EOL_CHAR;
`endif
                            end else if (mode_q == 2'd2) begin
                                bit_d  = bit_q - IDX_W'(1);
                                byte_d = cnt_q[bit_d] ? ASCII_1 : ASCII_0;
                            end else begin
                                pos_d  = pos_q + 8'd1;
                                byte_d = FIRST_CHAR + pos_d;
                            end
                        end
`ifdef ASCII_PATGEN_CR_EN
                        PH_CR: begin
                            phase_d = PH_EOL;
                            byte_d  = EOL_CHAR;
                        end
`endif
                        default: begin
                            // EOL finished: the line's own-mode position advances before the next line starts.
                            if (mode_q == 2'd0) k_d = (k_q == SPAN) ? 8'd0 : k_q + 8'd1;
                            if (mode_q == 2'd2) cnt_d = cnt_q + COUNT_W'(1);
                            if (ENABLE) line_start = 1'b1;
                            else        state_d    = IDLE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        if (line_start) begin
            state_d = SEND;
            mode_d  = MODE;
            phase_d = PH_DATA;
            pos_d   = 8'd0;
            bit_d   = TOP_BIT;
            byte_d  = (MODE == 2'd2) ? (cnt_d[COUNT_W-1] ? ASCII_1 : ASCII_0) : FIRST_CHAR;
        end
    end

    assign TX_DV     = (state_q == SEND);
    assign TX_BYTE   = byte_q;
    assign LINE_DONE = (state_q == SEND) && (phase_q == PH_EOL);
    assign BUSY      = (state_q != IDLE);

endmodule
